latch_input_debouncer: RTL and testbench
========================================

# latch_input_debouncer

Two-channel switch conditioner that sits directly upstream of the D latch stage and produces its `d` and `en` inputs. It takes raw, asynchronous, bouncing board switches, synchronizes them to `clk`, and filters each one. A channel's filtered output changes only after its synchronized input has held a new value for a programmable number of consecutive cycles. It also emits one-cycle pulses on filtered `en` edges so downstream logic can count latch open/close events.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4. Consecutive stable cycles required to accept a new level. Legal range is ≥1. Benches use 4; board builds override to about 500000.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`. Width of each channel's stability counter.

Ports:
- `clk`  input  1  Single system clock; all state is updated on its rising edge.
- `rst`  input  1  Asynchronous, active-high reset.
- `sw_d_raw`  input  1  Raw data switch; asynchronous and may bounce.
- `sw_en_raw`  input  1  Raw enable switch; asynchronous and may bounce.
- `d`  output  1  Filtered data level; drives the latch `d` input.
- `en`  output  1  Filtered enable level; drives the latch `en` input.
- `en_rise`  output  1  One-cycle pulse, high during the first cycle `en` reads 1.
- `en_fall`  output  1  One-cycle pulse, high during the first cycle `en` reads 0 after having been 1.

## Operation
- Each channel has a 2-flop synchronizer (`s1`, `s2`), followed by a 4-state FSM and a `CNT_W`-bit counter. The two channels are identical and fully independent.
- FSM states: `STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`. The channel output is 0 in `STABLE_LO` and `WAIT_HI`, and 1 in `STABLE_HI` and `WAIT_LO`.
- `STABLE_LO`:
  - If `s2`=1, go to `WAIT_HI` and set cnt=1.
  - Otherwise stay, with cnt=0.
- `WAIT_HI`:
  - If `s2`=0, go to `STABLE_LO` and set cnt=0. The glitch is rejected and the output never changes.
  - If `s2`=1 and cnt==`STABLE_CYCLES`, go to `STABLE_HI`, set the output to 1 and set cnt=0.
  - If `s2`=1 otherwise, increment cnt.
- `STABLE_HI` and `WAIT_LO` mirror the above with the polarity inverted.
- The counter never exceeds `STABLE_CYCLES`, so it never wraps.
- `en_rise` and `en_fall` are registered. They assert in the same cycle the `en` channel output changes and deassert on the next edge. They are never high together.
- Reset (`rst`=1, at any time, including mid-WAIT):
  - synchronizers, counters, `d`, `en`, `en_rise` and `en_fall` all go to 0 immediately;
  - both FSMs go to `STABLE_LO`;
  - any partial count is discarded.
- Release of `rst` takes effect at the next `clk` edge. A raw input already high at release is debounced from scratch.

## Timing
- Let a raw input change and stay stable before rising edge k.
  - `s1` updates at edge k and `s2` at k+1.
  - The FSM enters WAIT at k+2.
  - The output, and `en_rise`/`en_fall` for the `en` channel, update at edge k+2+`STABLE_CYCLES`.
  - Minimum latency is therefore `STABLE_CYCLES`+2 cycles.
- Any opposite-level `s2` sample during WAIT restarts the process. The qualifying run must be `STABLE_CYCLES`+1 consecutive `s2` samples at the new level.
- `d` and `en` change simultaneously when both raw inputs switch at the same edge. No ordering between the channels is imposed.
- Outputs are glitch-free registered signals. Output sampling setup to the latch is one full clock period.

## Test plan
All cases use `STABLE_CYCLES`=4.
1. **Clean rise.** Reset for 2 cycles, then set `sw_en_raw`=1 before edge 10. Required: `en` 0→1 and `en_rise`=1 at edge 16 only; `en_rise` back to 0 at edge 17; `d`=0 throughout.
2. **Bounce rejection.** Toggle `sw_d_raw` 1,0,1,0 on alternate cycles, then hold it at 0. Required: `d` stays 0 and no pulses occur.
3. **Bounce then settle.** Toggle `sw_d_raw` 1,0,1 with each value 2 cycles, then hold it at 1 from edge t. Required: `d`=1 exactly at edge t+6, not earlier.
4. **Falling edge.** With `en`=1 stable, set `sw_en_raw`=0 before edge k. Required: `en`=0 and `en_fall`=1 at edge k+6; `en_rise` stays 0.
5. **Reset mid-wait.** Set `sw_en_raw`=1 and assert `rst` 3 cycles later, between edges. Required:
   - all outputs read 0 immediately, without waiting for an edge;
   - after release with the raw input still 1, `en` rises 6 edges after the first post-release edge.
6. **Simultaneous.** Set both raw inputs to 1 at the same edge. Required: `d` and `en` rise on the same edge, and `en_rise` pulses once.

Source files
------------

// File: rtl/latch_input_debouncer.sv
// Two-channel switch conditioner feeding the D latch d/en inputs: sync + FSM debounce per channel.
// Latency: a new raw level appears on d/en (and en_rise/en_fall) STABLE_CYCLES+2 clocks after it settles.
// Backpressure: none; free-running, outputs are registered levels and one-cycle pulses.
module latch_input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_d_raw,
  input  logic sw_en_raw,
  output logic d,
  output logic en,
  output logic en_rise,
  output logic en_fall
);

  localparam logic [CNT_W-1:0] L_LIMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  // Bit 1 of the encoding is the filtered level, so the output comes
  // straight from a state flop and cannot glitch.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } state_t;

  // Channel 0 is d, channel 1 is en.
  logic [1:0] w_raw;
  logic [1:0] w_lvl;
  logic       w_en_nxt;
  logic       r_en_rise;
  logic       r_en_fall;

  assign w_raw = {sw_en_raw, sw_d_raw};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Two-flop synchronizer for the asynchronous raw switch.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
      end
    end

    // Debounce state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= STABLE_LO;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    // Next state: a level is accepted after STABLE_CYCLES+1 consecutive
    // synchronized samples; any opposite sample during WAIT falls back.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
        STABLE_LO: begin
          if (r_s2) begin
            w_state_nxt = WAIT_HI;
            w_cnt_nxt   = L_ONE;
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        WAIT_HI: begin
          if (!r_s2) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == L_LIMIT) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + L_ONE;
          end
        end
        STABLE_HI: begin
          if (!r_s2) begin
            w_state_nxt = WAIT_LO;
            w_cnt_nxt   = L_ONE;
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        WAIT_LO: begin
          if (r_s2) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == L_LIMIT) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + L_ONE;
          end
        end
        default: begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_lvl[g] = r_state[1];

    // Only the en channel needs its upcoming level for edge pulses.
    if (g == 1) begin : g_en_nxt
      assign w_en_nxt = w_state_nxt[1];
    end
  end

  // Edge pulses register alongside the en level so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_rise <= 1'b0;
      r_en_fall <= 1'b0;
    end else begin
      r_en_rise <= w_en_nxt & ~w_lvl[1];
      r_en_fall <= ~w_en_nxt & w_lvl[1];
    end
  end

  assign d       = w_lvl[0];
  assign en      = w_lvl[1];
  assign en_rise = r_en_rise;
  assign en_fall = r_en_fall;

endmodule

// File: tb/tb_latch_input_debouncer.sv
// Directed bench for latch_input_debouncer with STABLE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived: a level settled before edge k shows at edge k+6.
module tb_latch_input_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic sw_d_raw;
  logic sw_en_raw;
  logic d;
  logic en;
  logic en_rise;
  logic en_fall;

  int checks = 0;
  int errors = 0;

  latch_input_debouncer #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_d_raw  (sw_d_raw),
    .sw_en_raw (sw_en_raw),
    .d         (d),
    .en        (en),
    .en_rise   (en_rise),
    .en_fall   (en_fall)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ed, input logic een,
                         input logic erise, input logic efall);
    chk({tag, ".d"}, d, ed);
    chk({tag, ".en"}, en, een);
    chk({tag, ".en_rise"}, en_rise, erise);
    chk({tag, ".en_fall"}, en_fall, efall);
  endtask

  initial begin
    rst       = 1'b1;
    sw_d_raw  = 1'b0;
    sw_en_raw = 1'b0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
    step(2);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: clean rise on en
    sw_en_raw = 1'b1;
    step(6);
    chk_all("rise_k5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("rise_k6", 1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    chk_all("rise_k7", 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: one-cycle bounce on d is rejected
    sw_d_raw = 1'b1; step(1);
    sw_d_raw = 1'b0; step(1);
    sw_d_raw = 1'b1; step(1);
    sw_d_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_all("bounce", 1'b0, 1'b1, 1'b0, 1'b0);
    end

    // 3: two-cycle bounces, then settle high before edge t
    sw_d_raw = 1'b1; step(2);
    sw_d_raw = 1'b0; step(2);
    sw_d_raw = 1'b1; step(2);
    sw_d_raw = 1'b0; step(2);
    sw_d_raw = 1'b1;
    step(6);
    chk("settle_t5.d", d, 1'b0);
    step(1);
    chk("settle_t6.d", d, 1'b1);
    chk("settle_t6.en_rise", en_rise, 1'b0);

    // 4: falling edge on en
    sw_en_raw = 1'b0;
    step(6);
    chk_all("fall_k5", 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    chk_all("fall_k6", 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    chk_all("fall_k7", 1'b1, 1'b0, 1'b0, 1'b0);

    // 5: reset in the middle of the en WAIT_HI run
    sw_en_raw = 1'b1;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(6);
    chk_all("rel_j5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("rel_j6", 1'b1, 1'b1, 1'b1, 1'b0);

    // 6: both channels switch on the same edge
    sw_d_raw  = 1'b0;
    sw_en_raw = 1'b0;
    step(10);
    chk_all("both_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    sw_d_raw  = 1'b1;
    sw_en_raw = 1'b1;
    step(6);
    chk_all("simul_k5", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_all("simul_k6", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk_all("simul_after", 1'b1, 1'b1, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
